// File: rtl/lock_flight_ctrl.sv
// Flight-of-locks controller: walks one gondola chamber by chamber between the
// outer and inner reservoirs, equalising water across each gate before opening it.
module lock_flight_ctrl #(
    parameter int N_CHAMBERS  = 2,
    parameter int WW          = 8,
    parameter int STEP        = 1,
    parameter int RESET_LEVEL = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_in,
    input  logic                              req_out,
    input  logic                              gondola_moved,
    input  logic                              hold,
    input  logic [WW-1:0]                     outer_level,
    input  logic [WW-1:0]                     inner_level,
    output logic [N_CHAMBERS*WW-1:0]          levels,
    output logic [N_CHAMBERS:0]               gate_open,
    output logic [N_CHAMBERS-1:0]             fill,
    output logic [N_CHAMBERS-1:0]             drain,
    output logic [$clog2(N_CHAMBERS+2)-1:0]   pos,
    output logic                              dir,
    output logic                              busy,
    output logic                              done
);

    localparam int PW = $clog2(N_CHAMBERS + 2);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);
    localparam logic [PW-1:0] POS_LAST = PW'(N_CHAMBERS + 1);
    localparam logic [WW-1:0] STEP_W   = WW'(STEP);
    localparam logic [WW-1:0] LVL_RST  = WW'(RESET_LEVEL);

    typedef enum logic [1:0] {
        IDLE,
        MATCH,
        OPEN,
        CLOSE
    } state_t;

    state_t                  state, state_n;
    logic [WW-1:0]           lvl   [N_CHAMBERS];
    logic [WW-1:0]           lvl_n [N_CHAMBERS];
    logic [N_CHAMBERS:0]     gate_n;
    logic [N_CHAMBERS-1:0]   fill_n, drain_n;
    logic [PW-1:0]           pos_n;
    logic                    dir_n, busy_n, done_n;

    // Gate under service and the chamber/target pair it implies.
    int                      gi;
    int                      adj_idx;
    int                      src_idx;
    logic                    src_outer, src_inner;
    logic [WW-1:0]           cur, src_lvl, tgt, diff, nxt;

    always_comb begin
        gi        = dir ? int'(pos) - 1 : int'(pos);
        adj_idx   = 0;
        src_idx   = 0;
        src_outer = 1'b0;
        src_inner = 1'b0;
        if (!dir) begin
            if (gi == N_CHAMBERS) begin
                adj_idx   = gi - 1;
                src_inner = 1'b1;
            end else begin
                adj_idx   = gi;
                src_outer = (gi == 0);
                src_idx   = gi - 1;
            end
        end else begin
            if (gi == 0) begin
                adj_idx   = 0;
                src_outer = 1'b1;
            end else begin
                adj_idx   = gi - 1;
                src_inner = (gi == N_CHAMBERS);
                src_idx   = gi;
            end
        end

        cur     = '0;
        src_lvl = '0;
        for (int k = 0; k < N_CHAMBERS; k++) begin
            if (k == adj_idx) cur = lvl[k];
            if (k == src_idx) src_lvl = lvl[k];
        end
        tgt = src_outer ? outer_level : (src_inner ? inner_level : src_lvl);

        // Step toward the target, landing exactly on it once within one STEP.
        diff = (cur < tgt) ? (tgt - cur) : (cur - tgt);
        if (diff <= STEP_W) begin
            nxt = tgt;
        end else if (cur < tgt) begin
            nxt = cur + STEP_W;
        end else begin
            nxt = cur - STEP_W;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_n = state;
        lvl_n   = lvl;
        gate_n  = gate_open;
        fill_n  = '0;
        drain_n = '0;
        pos_n   = pos;
        dir_n   = dir;
        done_n  = 1'b0;

        if (!hold) begin
            case (state)
                IDLE: begin
                    if (req_in) begin
                        dir_n   = 1'b0;
                        pos_n   = '0;
                        state_n = MATCH;
                    end else if (req_out) begin
                        dir_n   = 1'b1;
                        pos_n   = POS_LAST;
                        state_n = MATCH;
                    end
                end
                MATCH: begin
                    if (cur == tgt) begin
                        state_n = OPEN;
                        for (int k = 0; k <= N_CHAMBERS; k++) begin
                            gate_n[k] = (k == gi);
                        end
                    end else begin
                        for (int k = 0; k < N_CHAMBERS; k++) begin
                            if (k == adj_idx) begin
                                lvl_n[k]   = nxt;
                                fill_n[k]  = (cur < tgt);
                                drain_n[k] = (cur > tgt);
                            end
                        end
                    end
                end
                OPEN: begin
                    if (gondola_moved) begin
                        gate_n  = '0;
                        pos_n   = dir ? (pos - POS_ONE) : (pos + POS_ONE);
                        state_n = CLOSE;
                    end
                end
                CLOSE: begin
                    if (dir ? (pos == '0) : (pos == POS_LAST)) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = MATCH;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            // NOTE: the level array is reset deliberately; chamber levels are architectural state.
            for (int k = 0; k < N_CHAMBERS; k++) lvl[k] <= LVL_RST;
            gate_open <= '0;
            fill      <= '0;
            drain     <= '0;
            pos       <= '0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            lvl       <= lvl_n;
            gate_open <= gate_n;
            fill      <= fill_n;
            drain     <= drain_n;
            pos       <= pos_n;
            dir       <= dir_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        levels = '0;
        for (int k = 0; k < N_CHAMBERS; k++) levels[k*WW +: WW] = lvl[k];
    end

endmodule

// File: tb/tb_lock_flight_ctrl.sv
// Directed bench for lock_flight_ctrl: two-chamber flight with STEP=4,
// hand-computed level, gate and position sequences.
module tb_lock_flight_ctrl;

    localparam int N  = 2;
    localparam int WW = 8;

    logic              clk = 1'b0;
    logic              rst, req_in, req_out, gondola_moved, hold;
    logic [WW-1:0]     outer_level, inner_level;
    logic [N*WW-1:0]   levels;
    logic [N:0]        gate_open;
    logic [N-1:0]      fill, drain;
    logic [1:0]        pos;
    logic              dir, busy, done;

    int n_chk = 0;
    int n_bad = 0;

    lock_flight_ctrl #(
        .N_CHAMBERS (N),
        .WW         (WW),
        .STEP       (4),
        .RESET_LEVEL(0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .req_out      (req_out),
        .gondola_moved(gondola_moved),
        .hold         (hold),
        .outer_level  (outer_level),
        .inner_level  (inner_level),
        .levels       (levels),
        .gate_open    (gate_open),
        .fill         (fill),
        .drain        (drain),
        .pos          (pos),
        .dir          (dir),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until a gate opens (bounded); checks which gate and how many cycles it took.
    task automatic wait_gate(input string tag, input logic [N:0] exp_gate, input int exp_cyc);
        int n;
        n = 0;
        while (gate_open == '0 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_gate"}, gate_open, exp_gate);
        check({tag, "_cyc"}, n, exp_cyc);
    endtask

    // Pulses gondola_moved in OPEN, checks CLOSE, then the cycle after CLOSE.
    task automatic do_move(input string tag, input logic [1:0] exp_pos, input logic exp_done);
        gondola_moved = 1'b1;
        step();
        gondola_moved = 1'b0;
        check({tag, "_close_gate"}, gate_open, 0);
        check({tag, "_pos"}, pos, exp_pos);
        step();
        check({tag, "_done"}, done, exp_done);
        check({tag, "_busy"}, busy, !exp_done);
    endtask

    initial begin
        int fills;
        int n;
        logic [WW-1:0] l1;

        rst = 1'b1; req_in = 1'b0; req_out = 1'b0; gondola_moved = 1'b0; hold = 1'b0;
        outer_level = 8'd8; inner_level = 8'd0;
        step(); step();
        rst = 1'b0;
        check("rst_levels", levels, 0);
        check("rst_gate", gate_open, 0);
        check("rst_fill", fill, 0);
        check("rst_drain", drain, 0);
        check("rst_pos", pos, 0);
        check("rst_dir", dir, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Inbound transit
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        check("in_busy", busy, 1);
        check("in_dir", dir, 0);
        check("in_pos", pos, 0);
        check("in_lvl_start", levels, 16'h0000);
        step();
        check("in_lvl0_4", levels, 16'h0004);
        check("in_fill0_a", fill, 2'b01);
        step();
        check("in_lvl0_8", levels, 16'h0008);
        check("in_fill0_b", fill, 2'b01);
        step();
        check("in_g0_open", gate_open, 3'b001);
        check("in_g0_fill", fill, 2'b00);
        do_move("in_g0", 2'd1, 1'b0);
        wait_gate("in_g1", 3'b010, 3);
        check("in_lvl1_8", levels, 16'h0808);
        do_move("in_g1", 2'd2, 1'b0);
        step();
        check("in_lvl1_4", levels, 16'h0408);
        check("in_drain1", drain, 2'b10);
        wait_gate("in_g2", 3'b100, 2);
        check("in_lvl1_0", levels, 16'h0008);
        do_move("in_g2", 2'd3, 1'b1);
        check("in_end_pos", pos, 3);
        check("in_end_lvls", levels, 16'h0008);
        step();
        check("in_done_pulse", done, 0);

        // Outbound straight after
        req_out = 1'b1;
        step();
        req_out = 1'b0;
        check("out_pos", pos, 3);
        check("out_dir", dir, 1);
        check("out_busy", busy, 1);
        wait_gate("out_g2", 3'b100, 1);
        check("out_g2_fill", fill, 0);
        check("out_g2_drain", drain, 0);
        do_move("out_g2", 2'd2, 1'b0);
        wait_gate("out_g1", 3'b010, 3);
        check("out_lvl_g1", levels, 16'h0000);
        do_move("out_g1", 2'd1, 1'b0);
        wait_gate("out_g0", 3'b001, 3);
        check("out_lvl_g0", levels, 16'h0008);
        do_move("out_g0", 2'd0, 1'b1);
        check("out_end_pos", pos, 0);

        // Non-multiple step: 0 -> 4 -> 7
        rst = 1'b1;
        step();
        rst = 1'b0;
        outer_level = 8'd7;
        check("nm_rst_lvls", levels, 0);
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        fills = 0;
        n = 0;
        l1 = '0;
        while (gate_open == '0 && n < 20) begin
            step();
            n++;
            if (fill[0]) fills++;
            if (n == 1) l1 = levels[7:0];
        end
        check("nm_fill_cycles", fills, 2);
        check("nm_first_step", l1, 4);
        check("nm_final_lvl", levels[7:0], 7);
        check("nm_gate", gate_open, 3'b001);

        // Simultaneous requests, re-request while busy, hold, stray pulse
        rst = 1'b1;
        step();
        rst = 1'b0;
        outer_level = 8'd8;
        req_in = 1'b1;
        req_out = 1'b1;
        step();
        req_in = 1'b0;
        check("both_dir", dir, 0);
        check("both_pos", pos, 0);
        step();
        req_out = 1'b0;
        check("busy_req_dir", dir, 0);
        check("busy_req_pos", pos, 0);
        check("busy_req_lvl", levels, 16'h0004);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_lvl", levels, 16'h0004);
            check("hold_fill", fill, 0);
            check("hold_busy", busy, 1);
        end
        hold = 1'b0;
        gondola_moved = 1'b1;
        step();
        gondola_moved = 1'b0;
        check("resume_lvl", levels, 16'h0008);
        check("resume_fill", fill, 2'b01);
        check("stray_pos", pos, 0);
        step();
        check("stray_gate", gate_open, 3'b001);
        check("stray_pos2", pos, 0);
        do_move("rs_g0", 2'd1, 1'b0);
        wait_gate("rs_g1", 3'b010, 3);

        // Reset during OPEN of gate 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_gate", gate_open, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pos", pos, 0);
        check("mid_rst_lvls", levels, 0);
        check("mid_rst_dir", dir, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
